// File: rtl/exec_alu_pkg.sv
// Shared encodings for the RV32 execute-stage ALU: control codes, alu_op values,
// branch funct3 values and R-type funct7 values.
package exec_alu_pkg;

    typedef logic [3:0] alu_ctrl_t;

    localparam alu_ctrl_t CTRL_AND    = 4'b0000;
    localparam alu_ctrl_t CTRL_OR     = 4'b0001;
    localparam alu_ctrl_t CTRL_ADD    = 4'b0010;
    localparam alu_ctrl_t CTRL_XOR    = 4'b0011;
    localparam alu_ctrl_t CTRL_SLL    = 4'b0100;
    localparam alu_ctrl_t CTRL_SRL    = 4'b0101;
    localparam alu_ctrl_t CTRL_SUB    = 4'b0110;
    localparam alu_ctrl_t CTRL_SRA    = 4'b0111;
    localparam alu_ctrl_t CTRL_SLT    = 4'b1000;
    localparam alu_ctrl_t CTRL_SLTU   = 4'b1001;
    localparam alu_ctrl_t CTRL_MUL    = 4'b1010;
    localparam alu_ctrl_t CTRL_MULH   = 4'b1011;
    localparam alu_ctrl_t CTRL_MULHSU = 4'b1100;
    localparam alu_ctrl_t CTRL_MULHU  = 4'b1101;
    localparam alu_ctrl_t CTRL_RSVD   = 4'b1110;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Base integer-op table shared by R-type funct7=0000000 and I-type arithmetic.
    function automatic alu_ctrl_t base_ctrl(input logic [2:0] f3);
        alu_ctrl_t c;
        case (f3)
            3'b000:  c = CTRL_ADD;
            3'b001:  c = CTRL_SLL;
            3'b010:  c = CTRL_SLT;
            3'b011:  c = CTRL_SLTU;
            3'b100:  c = CTRL_XOR;
            3'b101:  c = CTRL_SRL;
            3'b110:  c = CTRL_OR;
            3'b111:  c = CTRL_AND;
            default: c = CTRL_RSVD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/exec_alu_decode.sv
// Combinational alu_op/funct3/funct7 -> 4-bit ALU control decode.
// Multiply codes are produced only when EXEC_ALU_MUL_EN is defined.
module exec_alu_decode
    import exec_alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] ctrl_lines
);

    alu_ctrl_t ctrl_s;

    // Control-code selection from the instruction fields.
    always_comb begin
        ctrl_s = CTRL_RSVD;
        case (alu_op)
            ALUOP_ADD: begin
                ctrl_s = CTRL_ADD;
            end
            ALUOP_BRANCH: begin
                case (funct3)
                    F3_BEQ, F3_BNE:   ctrl_s = CTRL_SUB;
                    F3_BLT, F3_BGE:   ctrl_s = CTRL_SLT;
                    F3_BLTU, F3_BGEU: ctrl_s = CTRL_SLTU;
                    default:          ctrl_s = CTRL_ADD;
                endcase
            end
            ALUOP_RTYPE: begin
                case (funct7)
                    F7_BASE: begin
                        ctrl_s = base_ctrl(funct3);
                    end
                    F7_ALT: begin
                        case (funct3)
                            3'b000:  ctrl_s = CTRL_SUB;
                            3'b101:  ctrl_s = CTRL_SRA;
                            default: ctrl_s = CTRL_RSVD;
                        endcase
                    end
`ifdef EXEC_ALU_MUL_EN
                    F7_MULDIV: begin
                        case (funct3)
                            3'b000:  ctrl_s = CTRL_MUL;
                            3'b001:  ctrl_s = CTRL_MULH;
                            3'b010:  ctrl_s = CTRL_MULHSU;
                            3'b011:  ctrl_s = CTRL_MULHU;
                            default: ctrl_s = CTRL_RSVD;
                        endcase
                    end
`endif
                    default: begin
                        ctrl_s = CTRL_RSVD;
                    end
                endcase
            end
            ALUOP_ITYPE: begin
                // I-type immediates overlap funct7, so only bit 5 matters and only for shifts right.
                case (funct3)
                    3'b000: ctrl_s = CTRL_ADD;
                    3'b101: begin
                        if (funct7[5]) begin
                            ctrl_s = CTRL_SRA;
                        end else begin
                            ctrl_s = CTRL_SRL;
                        end
                    end
                    default: ctrl_s = base_ctrl(funct3);
                endcase
            end
            default: begin
                ctrl_s = CTRL_RSVD;
            end
        endcase
    end

    assign ctrl_lines = ctrl_s;

endmodule

// File: rtl/exec_alu_unit.sv
// RV32 execute-stage ALU with branch compare and PC+imm adder; all outputs registered.
// Define EXEC_ALU_MUL_EN to build the multiplier (MUL/MULH/MULHSU/MULHU and mul_res).
module exec_alu_unit
    import exec_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [1:0]          alu_op,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic [XLEN-1:0]     op_a,
    input  logic [XLEN-1:0]     op_b,
    input  logic [XLEN-1:0]     pc,
    input  logic [XLEN-1:0]     imm,
    output logic                out_valid,
    output logic [3:0]          ctrl_lines,
    output logic [XLEN-1:0]     result,
    output logic [2*XLEN-1:0]   mul_res,
    output logic                zero_flag,
    output logic                branch,
    output logic [XLEN-1:0]     pc_imm_sum
);

    alu_ctrl_t              ctrl_s;
    logic [XLEN-1:0]        result_s;
    logic                   branch_s;
    logic                   lt_s;
    logic                   ltu_s;
    logic [4:0]             shamt_s;

    logic                   out_valid_r;
    alu_ctrl_t              ctrl_r;
    logic [XLEN-1:0]        result_r;
    logic                   zero_r;
    logic                   branch_r;
    logic [XLEN-1:0]        pc_imm_sum_r;

    exec_alu_decode u_decode (
        .alu_op     (alu_op),
        .funct3     (funct3),
        .funct7     (funct7),
        .ctrl_lines (ctrl_s)
    );

    assign lt_s    = $signed(op_a) < $signed(op_b);
    assign ltu_s   = op_a < op_b;
    assign shamt_s = op_b[4:0];

`ifdef EXEC_ALU_MUL_EN
    logic [2*XLEN-1:0]      prod_ss_s;
    logic [2*XLEN-1:0]      prod_x_s;
    logic                   mul_a_ext_s;

    // Signed x signed product feeds mul_res and MULH; the second product's op_a
    // extension is chosen per code, and its low half also serves MUL.
    always_comb begin
        mul_a_ext_s = (ctrl_s == CTRL_MULHSU) ? op_a[XLEN-1] : 1'b0;
        prod_ss_s   = {{XLEN{op_a[XLEN-1]}}, op_a} * {{XLEN{op_b[XLEN-1]}}, op_b};
        prod_x_s    = {{XLEN{mul_a_ext_s}}, op_a} * {{XLEN{1'b0}}, op_b};
    end
`endif

    // Result mux over all control codes.
    always_comb begin
        result_s = {XLEN{1'b0}};
        case (ctrl_s)
            CTRL_AND:    result_s = op_a & op_b;
            CTRL_OR:     result_s = op_a | op_b;
            CTRL_ADD:    result_s = op_a + op_b;
            CTRL_XOR:    result_s = op_a ^ op_b;
            CTRL_SLL:    result_s = op_a << shamt_s;
            CTRL_SRL:    result_s = op_a >> shamt_s;
            CTRL_SUB:    result_s = op_a - op_b;
            CTRL_SRA:    result_s = $unsigned($signed(op_a) >>> shamt_s);
            CTRL_SLT:    result_s = {{(XLEN-1){1'b0}}, lt_s};
            CTRL_SLTU:   result_s = {{(XLEN-1){1'b0}}, ltu_s};
`ifdef EXEC_ALU_MUL_EN
            CTRL_MUL:    result_s = prod_x_s[XLEN-1:0];
            CTRL_MULH:   result_s = prod_ss_s[2*XLEN-1:XLEN];
            CTRL_MULHSU: result_s = prod_x_s[2*XLEN-1:XLEN];
            CTRL_MULHU:  result_s = prod_x_s[2*XLEN-1:XLEN];
`endif
            default:     result_s = {XLEN{1'b0}};
        endcase
    end

    // Branch condition, only meaningful for alu_op=01.
    always_comb begin
        branch_s = 1'b0;
        if (alu_op == ALUOP_BRANCH) begin
            case (funct3)
                F3_BEQ:  branch_s = (op_a == op_b);
                F3_BNE:  branch_s = (op_a != op_b);
                F3_BLT:  branch_s = lt_s;
                F3_BGE:  branch_s = ~lt_s;
                F3_BLTU: branch_s = ltu_s;
                F3_BGEU: branch_s = ~ltu_s;
                default: branch_s = 1'b0;
            endcase
        end else begin
            branch_s = 1'b0;
        end
    end

    // Output registers; loaded every edge regardless of in_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r  <= 1'b0;
            ctrl_r       <= 4'b0000;
            result_r     <= {XLEN{1'b0}};
            zero_r       <= 1'b0;
            branch_r     <= 1'b0;
            pc_imm_sum_r <= {XLEN{1'b0}};
        end else begin
            out_valid_r  <= in_valid;
            ctrl_r       <= ctrl_s;
            result_r     <= result_s;
            zero_r       <= (result_s == {XLEN{1'b0}});
            branch_r     <= branch_s;
            pc_imm_sum_r <= pc + imm;
        end
    end

`ifdef EXEC_ALU_MUL_EN
    logic [2*XLEN-1:0]      mul_res_r;

    // Full signed product register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_res_r <= {(2*XLEN){1'b0}};
        end else begin
            mul_res_r <= prod_ss_s;
        end
    end

    assign mul_res = mul_res_r;
`else
    assign mul_res = {(2*XLEN){1'b0}};
`endif

    assign out_valid  = out_valid_r;
    assign ctrl_lines = ctrl_r;
    assign result     = result_r;
    assign zero_flag  = zero_r;
    assign branch     = branch_r;
    assign pc_imm_sum = pc_imm_sum_r;

endmodule

// File: tb/tb_exec_alu_unit.sv
// Scoreboard bench for exec_alu_unit: directed vectors push expectations, a
// negedge monitor pops and compares whenever out_valid is high.
module tb_exec_alu_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  alu_op = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic [6:0]  funct7 = 7'b0000000;
    logic [31:0] op_a = 32'h0;
    logic [31:0] op_b = 32'h0;
    logic [31:0] pc = 32'h0;
    logic [31:0] imm = 32'h0;
    logic        out_valid;
    logic [3:0]  ctrl_lines;
    logic [31:0] result;
    logic [63:0] mul_res;
    logic        zero_flag;
    logic        branch;
    logic [31:0] pc_imm_sum;

`ifdef EXEC_ALU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        zero;
        logic        br;
        logic [31:0] sum;
        logic        chk_mul;
        logic [63:0] mul;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    exec_alu_unit dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .alu_op     (alu_op),
        .funct3     (funct3),
        .funct7     (funct7),
        .op_a       (op_a),
        .op_b       (op_b),
        .pc         (pc),
        .imm        (imm),
        .out_valid  (out_valid),
        .ctrl_lines (ctrl_lines),
        .result     (result),
        .mul_res    (mul_res),
        .zero_flag  (zero_flag),
        .branch     (branch),
        .pc_imm_sum (pc_imm_sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"}, {63'h0, out_valid}, 64'h0);
        check({tag, ".ctrl"}, {60'h0, ctrl_lines}, 64'h0);
        check({tag, ".result"}, {32'h0, result}, 64'h0);
        check({tag, ".mul_res"}, mul_res, 64'h0);
        check({tag, ".zero"}, {63'h0, zero_flag}, 64'h0);
        check({tag, ".branch"}, {63'h0, branch}, 64'h0);
        check({tag, ".pc_sum"}, {32'h0, pc_imm_sum}, 64'h0);
    endtask

    task automatic issue(input string name, input logic [1:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] e_ctrl, input logic [31:0] e_res, input logic e_br,
                         input logic [31:0] pc_v = 32'h1000, input logic [31:0] imm_v = 32'h20,
                         input logic [31:0] e_sum = 32'h1020, input logic chk_mul = 1'b0,
                         input logic [63:0] e_mul = 64'h0);
        exp_t e;
        e.name = name; e.ctrl = e_ctrl; e.res = e_res; e.zero = (e_res == 32'h0);
        e.br = e_br; e.sum = e_sum; e.chk_mul = chk_mul; e.mul = e_mul;
        exp_q.push_back(e);
        in_valid = 1'b1; alu_op = op; funct3 = f3; funct7 = f7;
        op_a = a; op_b = b; pc = pc_v; imm = imm_v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: compare every valid output against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got result 0x%0h, required no output", result);
            end else begin
                e = exp_q.pop_front();
                check({e.name, ".ctrl"}, {60'h0, ctrl_lines}, {60'h0, e.ctrl});
                check({e.name, ".result"}, {32'h0, result}, {32'h0, e.res});
                check({e.name, ".zero"}, {63'h0, zero_flag}, {63'h0, e.zero});
                check({e.name, ".branch"}, {63'h0, branch}, {63'h0, e.br});
                check({e.name, ".pc_sum"}, {32'h0, pc_imm_sum}, {32'h0, e.sum});
                if (e.chk_mul) begin
                    check({e.name, ".mul_res"}, mul_res, e.mul);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] mul_exp;
        mul_exp = MUL_ON ? 64'hFFFF_FFFF_FFFF_FFFE : 64'h0;

        // Reset held with random inputs
        in_valid = 1'b1; alu_op = 2'($urandom()); funct3 = 3'($urandom()); funct7 = 7'($urandom());
        op_a = $urandom(); op_b = $urandom(); pc = $urandom(); imm = $urandom();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_hold");
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("after_release");

        issue("add_5_7",   2'b00, 3'b000, 7'h00, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0);
        issue("sub_zero",  2'b10, 3'b000, 7'h20, 32'd3, 32'd3, 4'b0110, 32'h0, 1'b0);
        issue("sra_r",     2'b10, 3'b101, 7'h20, 32'h8000_0000, 32'd4, 4'b0111, 32'hF800_0000, 1'b0);
        issue("slti",      2'b11, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 4'b1000, 32'd1, 1'b0);
        issue("sltiu",     2'b11, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 4'b1001, 32'd0, 1'b0);
        issue("blt",       2'b01, 3'b100, 7'h00, 32'hFFFF_FFFE, 32'd1, 4'b1000, 32'd1, 1'b1);
        issue("bltu",      2'b01, 3'b110, 7'h00, 32'hFFFF_FFFE, 32'd1, 4'b1001, 32'd0, 1'b0);
        issue("bne_eq",    2'b01, 3'b001, 7'h00, 32'h1234, 32'h1234, 4'b0110, 32'h0, 1'b0);
        issue("br_f3_010", 2'b01, 3'b010, 7'h00, 32'h1234, 32'h1234, 4'b0010, 32'h2468, 1'b0);
        issue("beq",       2'b01, 3'b000, 7'h00, 32'h1234, 32'h1234, 4'b0110, 32'h0, 1'b1);
        issue("bge",       2'b01, 3'b101, 7'h00, 32'hFFFF_FFFE, 32'd1, 4'b1000, 32'd1, 1'b0);
        issue("bgeu",      2'b01, 3'b111, 7'h00, 32'hFFFF_FFFE, 32'd1, 4'b1001, 32'd0, 1'b1);
        issue("sll",       2'b10, 3'b001, 7'h00, 32'd1, 32'd4, 4'b0100, 32'h10, 1'b0);
        issue("sll_shamt", 2'b10, 3'b001, 7'h00, 32'd1, 32'h24, 4'b0100, 32'h10, 1'b0);
        issue("srl_r",     2'b10, 3'b101, 7'h00, 32'h8000_0000, 32'd4, 4'b0101, 32'h0800_0000, 1'b0);
        issue("xor",       2'b10, 3'b100, 7'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0011, 32'h0FF0_0FF0, 1'b0);
        issue("or",        2'b10, 3'b110, 7'h00, 32'hF0F0_F0F0, 32'h0F0F_0000, 4'b0001, 32'hFFFF_F0F0, 1'b0);
        issue("and",       2'b10, 3'b111, 7'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 32'hF000_F000, 1'b0);
        issue("alt_rsvd",  2'b10, 3'b010, 7'h20, 32'd1, 32'd2, 4'b1110, 32'h0, 1'b0);
        issue("f7_rsvd",   2'b10, 3'b000, 7'h7F, 32'd1, 32'd2, 4'b1110, 32'h0, 1'b0);
        issue("addi_f7",   2'b11, 3'b000, 7'h20, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0);
        issue("srai",      2'b11, 3'b101, 7'h20, 32'h8000_0000, 32'd4, 4'b0111, 32'hF800_0000, 1'b0);
        issue("srli",      2'b11, 3'b101, 7'h00, 32'h8000_0000, 32'd4, 4'b0101, 32'h0800_0000, 1'b0);
        issue("add_wrap",  2'b00, 3'b000, 7'h00, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'h0, 1'b0);
        issue("pc_wrap",   2'b00, 3'b000, 7'h00, 32'd0, 32'd0, 4'b0010, 32'h0, 1'b0,
              32'hFFFF_FFFC, 32'd8, 32'h0000_0004);
        issue("pc_neg",    2'b00, 3'b000, 7'h00, 32'd2, 32'd3, 4'b0010, 32'd5, 1'b0,
              32'h1000, 32'hFFFF_FFF0, 32'h0000_0FF0);
        issue("mul",       2'b10, 3'b000, 7'h01, 32'hFFFF_FFFF, 32'd2,
              MUL_ON ? 4'b1010 : 4'b1110, MUL_ON ? 32'hFFFF_FFFE : 32'h0, 1'b0,
              32'h1000, 32'h20, 32'h1020, 1'b1, mul_exp);
        issue("mulh",      2'b10, 3'b001, 7'h01, 32'hFFFF_FFFF, 32'd2,
              MUL_ON ? 4'b1011 : 4'b1110, MUL_ON ? 32'hFFFF_FFFF : 32'h0, 1'b0,
              32'h1000, 32'h20, 32'h1020, 1'b1, mul_exp);
        issue("mulhsu",    2'b10, 3'b010, 7'h01, 32'hFFFF_FFFF, 32'd2,
              MUL_ON ? 4'b1100 : 4'b1110, MUL_ON ? 32'hFFFF_FFFF : 32'h0, 1'b0,
              32'h1000, 32'h20, 32'h1020, 1'b1, mul_exp);
        issue("mulhu",     2'b10, 3'b011, 7'h01, 32'hFFFF_FFFF, 32'd2,
              MUL_ON ? 4'b1101 : 4'b1110, MUL_ON ? 32'h0000_0001 : 32'h0, 1'b0,
              32'h1000, 32'h20, 32'h1020, 1'b1, mul_exp);
        issue("mul_rsvd",  2'b10, 3'b100, 7'h01, 32'hFFFF_FFFF, 32'd2, 4'b1110, 32'h0, 1'b0,
              32'h1000, 32'h20, 32'h1020, 1'b1, mul_exp);

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'h0);

        // Outputs load even when in_valid is low; only out_valid tracks it
        in_valid = 1'b0; alu_op = 2'b00; op_a = 32'd5; op_b = 32'd7; pc = 32'h10; imm = 32'h4;
        @(posedge clk);
        #1;
        check("idle.out_valid", {63'h0, out_valid}, 64'h0);
        check("idle.result", {32'h0, result}, 64'd12);

        // In-flight result discarded by an asynchronous reset between edges
        in_valid = 1'b1; op_a = 32'd9; op_b = 32'd9;
        @(posedge clk);
        #1;
        check("inflight.out_valid", {63'h0, out_valid}, 64'h1);
        check("inflight.result", {32'h0, result}, 64'd18);
        check("inflight.pc_sum", {32'h0, pc_imm_sum}, 64'h14);
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset.out_valid", {63'h0, out_valid}, 64'h0);
        check("final_queue_empty", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
